// File: rtl/hamming_pkg.sv
// rtl/hamming_pkg.sv - Hamming(12,8) receive constants, timing states and position helpers
package hamming_pkg;

    localparam int DATA_W = 8;
    localparam int PAR_W  = 4;
    localparam int CW_W   = DATA_W + PAR_W;

    typedef enum logic [2:0] {
        T0 = 3'd0,
        T1 = 3'd1,
        T2 = 3'd2,
        T3 = 3'd3,
        T4 = 3'd4,
        T5 = 3'd5
    } t_state_e;

    // Code positions (1-based) carrying data, LSB of the data byte first
    localparam int DATA_POS [DATA_W] = '{3, 5, 6, 7, 9, 10, 11, 12};

    function automatic logic is_parity_pos(input int p);
        return (p > 0) && ((p & (p - 1)) == 0);
    endfunction

endpackage

// File: rtl/hamming_rx_corrector_if.sv
// rtl/hamming_rx_corrector_if.sv - codeword input and corrected-data output handshake bundle
interface hamming_rx_corrector_if #(
    parameter int DATA_W = 8,
    parameter int PAR_W  = 4,
    parameter int CW_W   = 12
);
    logic              in_valid;
    logic              in_ready;
    logic [CW_W-1:0]   in_cw;
    logic              out_valid;
    logic              out_ready;
    logic [DATA_W-1:0] out_data;
    logic [PAR_W-1:0]  out_syndrome;
    logic              err_corrected;
    logic              err_uncorr;

    modport slave (
        input  in_valid, in_cw, out_ready,
        output in_ready, out_valid, out_data, out_syndrome, err_corrected, err_uncorr
    );

    modport master (
        output in_valid, in_cw, out_ready,
        input  in_ready, out_valid, out_data, out_syndrome, err_corrected, err_uncorr
    );
endinterface

// File: rtl/hamming_syndrome_bit.sv
// rtl/hamming_syndrome_bit.sv - one syndrome bit: parity of all code positions with bit i_idx set
module hamming_syndrome_bit #(
    parameter int CW_W  = 12,
    parameter int PAR_W = 4
) (
    input  logic [CW_W-1:0]  i_cw,
    input  logic [PAR_W-1:0] i_idx,
    output logic             o_bit
);
    always_comb begin
        o_bit = 1'b0;
        for (int p = 1; p <= CW_W; p++) begin
            if (((p >> i_idx) & 1) != 0) begin
                o_bit = o_bit ^ i_cw[p-1];
            end
        end
    end
endmodule

// File: rtl/hamming_rx_corrector.sv
// rtl/hamming_rx_corrector.sv - Hamming(12,8) decoder sequenced by timing states T0..T5
module hamming_rx_corrector
    import hamming_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst,
    hamming_rx_corrector_if.slave bus,
    output logic [7:0]            t_state
);
    localparam logic [PAR_W-1:0] LAST_POS = PAR_W'(CW_W);

    t_state_e          r_state;
    logic [CW_W-1:0]   r_cw;
    logic [PAR_W-2:0]  r_syn;
    logic [PAR_W-1:0]  r_out_syn;
    logic [DATA_W-1:0] r_out_data;
    logic              r_err_corr;
    logic              r_err_uncorr;

    logic [PAR_W-1:0]  w_idx;
    logic              w_syn_bit;
    logic [PAR_W-1:0]  w_syn_full;
    logic [CW_W-1:0]   w_flip;
    logic [CW_W-1:0]   w_cw_corr;
    logic [DATA_W-1:0] w_data;

    always_comb begin
        case (r_state)
            T2:      w_idx = PAR_W'(1);
            T3:      w_idx = PAR_W'(2);
            T4:      w_idx = PAR_W'(3);
            default: w_idx = '0;
        endcase
    end

    hamming_syndrome_bit #(
        .CW_W  (CW_W),
        .PAR_W (PAR_W)
    ) u_syn_bit (
        .i_cw  (r_cw),
        .i_idx (w_idx),
        .o_bit (w_syn_bit)
    );

    // Top syndrome bit is still on the wire in T4, so correction uses it directly
    assign w_syn_full = {w_syn_bit, r_syn};

    always_comb begin
        w_flip = '0;
        for (int p = 1; p <= CW_W; p++) begin
            if (w_syn_full == PAR_W'(p)) begin
                w_flip[p-1] = 1'b1;
            end
        end
    end

    assign w_cw_corr = r_cw ^ w_flip;

    always_comb begin
        w_data = '0;
        for (int i = 0; i < DATA_W; i++) begin
            w_data[i] = w_cw_corr[DATA_POS[i]-1];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= T0;
            r_cw         <= '0;
            r_syn        <= '0;
            r_out_syn    <= '0;
            r_out_data   <= '0;
            r_err_corr   <= 1'b0;
            r_err_uncorr <= 1'b0;
        end else begin
            case (r_state)
                T0: begin
                    if (bus.in_valid) begin
                        r_cw    <= bus.in_cw;
                        r_syn   <= '0;
                        r_state <= T1;
                    end
                end
                T1: begin
                    r_syn[0] <= w_syn_bit;
                    r_state  <= T2;
                end
                T2: begin
                    r_syn[1] <= w_syn_bit;
                    r_state  <= T3;
                end
                T3: begin
                    r_syn[2] <= w_syn_bit;
                    r_state  <= T4;
                end
                T4: begin
                    r_out_data   <= w_data;
                    r_out_syn    <= w_syn_full;
                    r_err_corr   <= (w_syn_full != '0) && (w_syn_full <= LAST_POS);
                    r_err_uncorr <= (w_syn_full > LAST_POS);
                    r_state      <= T5;
                end
                T5: begin
                    if (bus.out_ready) begin
                        r_state <= T0;
                    end
                end
                default: r_state <= T0;
            endcase
        end
    end

    assign bus.in_ready      = (r_state == T0);
    assign bus.out_valid     = (r_state == T5);
    assign bus.out_data      = r_out_data;
    assign bus.out_syndrome  = r_out_syn;
    assign bus.err_corrected = r_err_corr;
    assign bus.err_uncorr    = r_err_uncorr;

    always_comb begin
        case (r_state)
            T0:      t_state = 8'h01;
            T1:      t_state = 8'h02;
            T2:      t_state = 8'h04;
            T3:      t_state = 8'h08;
            T4:      t_state = 8'h10;
            T5:      t_state = 8'h20;
            default: t_state = 8'h00;
        endcase
    end
endmodule

// File: tb/tb_hamming_rx_corrector.sv
// tb/tb_hamming_rx_corrector.sv - randomized self-checking bench for hamming_rx_corrector
module tb_hamming_rx_corrector;
    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] t_state;
    int         checks = 0;
    int         failures = 0;

    hamming_rx_corrector_if bus_if ();

    hamming_rx_corrector dut (
        .clk     (clk),
        .rst     (rst),
        .bus     (bus_if.slave),
        .t_state (t_state)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Syndrome = XOR of the position numbers of all set bits
    task automatic ref_decode(input logic [11:0] cw, output logic [7:0] d, output logic [3:0] s,
                              output logic ec, output logic eu);
        int syn;
        int k;
        logic [11:0] c;
        syn = 0;
        k = 0;
        for (int p = 1; p <= 12; p++) if (cw[p-1]) syn = syn ^ p;
        c = cw;
        if (syn >= 1 && syn <= 12) c[syn-1] = ~c[syn-1];
        ec = (syn >= 1 && syn <= 12);
        eu = (syn > 12);
        s = 4'(syn);
        d = '0;
        for (int p = 1; p <= 12; p++) begin
            if (p != 1 && p != 2 && p != 4 && p != 8) begin
                d[k] = c[p-1];
                k++;
            end
        end
    endtask

    function automatic logic [11:0] encode(input logic [7:0] d);
        logic [11:0] cw;
        int syn;
        int k;
        cw = '0;
        k = 0;
        syn = 0;
        for (int p = 1; p <= 12; p++) begin
            if (p != 1 && p != 2 && p != 4 && p != 8) begin
                cw[p-1] = d[k];
                k++;
                if (cw[p-1]) syn = syn ^ p;
            end
        end
        for (int i = 0; i < 4; i++) cw[(1 << i) - 1] = syn[i];
        return cw;
    endfunction

    task automatic run_word(input logic [11:0] cw);
        int waited;
        int lat;
        waited = 0;
        while (bus_if.in_ready !== 1'b1 && waited < 20) begin
            @(posedge clk); #1;
            waited++;
        end
        chk("in_ready_wait", 32'(bus_if.in_ready), 32'd1);
        bus_if.in_valid = 1'b1;
        bus_if.in_cw    = cw;
        @(posedge clk); #1;
        bus_if.in_valid = 1'b0;
        bus_if.in_cw    = 12'($urandom);
        lat = 1;
        while (bus_if.out_valid !== 1'b1 && lat < 20) begin
            chk("t_walk", 32'(t_state), 32'd1 << lat);
            @(posedge clk); #1;
            lat++;
        end
        chk("latency", lat, 5);
        chk("t_state_out", 32'(t_state), 32'h20);
    endtask

    task automatic check_out(input string tag, input logic [7:0] d, input logic [3:0] s,
                             input logic ec, input logic eu);
        chk({tag, "_data"}, 32'(bus_if.out_data), 32'(d));
        chk({tag, "_syn"}, 32'(bus_if.out_syndrome), 32'(s));
        chk({tag, "_ec"}, 32'(bus_if.err_corrected), 32'(ec));
        chk({tag, "_eu"}, 32'(bus_if.err_uncorr), 32'(eu));
    endtask

    task automatic handshake();
        bus_if.out_ready = 1'b1;
        @(posedge clk); #1;
        chk("hs_out_valid", 32'(bus_if.out_valid), 32'd0);
        chk("hs_in_ready", 32'(bus_if.in_ready), 32'd1);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1);
    end

    initial begin
        logic [7:0]  d, md;
        logic [3:0]  ms;
        logic        mec, meu;
        logic [11:0] cw;
        int          mode, pa, pb;

        rst = 1'b1;
        bus_if.in_valid  = 1'b0;
        bus_if.in_cw     = '0;
        bus_if.out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_t_state", 32'(t_state), 32'h01);
        chk("rst_in_ready", 32'(bus_if.in_ready), 32'd1);
        chk("rst_out_valid", 32'(bus_if.out_valid), 32'd0);
        check_out("rst", 8'h00, 4'd0, 1'b0, 1'b0);
        rst = 1'b0;

        run_word(12'hA27); check_out("clean", 8'hA5, 4'd0, 1'b0, 1'b0); handshake();
        run_word(12'hA07); check_out("data_err", 8'hA5, 4'd6, 1'b1, 1'b0); handshake();
        run_word(12'hAA7); check_out("par_err", 8'hA5, 4'd8, 1'b1, 1'b0); handshake();
        run_word(12'h226); check_out("uncorr", 8'h25, 4'd13, 1'b0, 1'b1); handshake();

        bus_if.out_ready = 1'b0;
        run_word(12'hA07);
        for (int i = 0; i < 10; i++) begin
            bus_if.in_valid = 1'b1;
            bus_if.in_cw    = 12'($urandom);
            @(posedge clk); #1;
            chk("bp_out_valid", 32'(bus_if.out_valid), 32'd1);
            chk("bp_in_ready", 32'(bus_if.in_ready), 32'd0);
            check_out("bp", 8'hA5, 4'd6, 1'b1, 1'b0);
        end
        bus_if.in_valid = 1'b0;
        handshake();
        check_out("bp_held", 8'hA5, 4'd6, 1'b1, 1'b0);

        bus_if.in_valid = 1'b1;
        bus_if.in_cw    = 12'hA27;
        @(posedge clk); #1;
        bus_if.in_valid = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        chk("mid_t3", 32'(t_state), 32'h08);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        chk("mid_rst_t_state", 32'(t_state), 32'h01);
        chk("mid_rst_out_valid", 32'(bus_if.out_valid), 32'd0);
        chk("mid_rst_in_ready", 32'(bus_if.in_ready), 32'd1);
        run_word(12'hAA7); check_out("post_rst", 8'hA5, 4'd8, 1'b1, 1'b0); handshake();

        for (int n = 0; n < 40; n++) begin
            d    = 8'($urandom);
            mode = $urandom_range(0, 3);
            cw   = encode(d);
            pa   = $urandom_range(0, 11);
            pb   = (pa + $urandom_range(1, 11)) % 12;
            if (mode == 1) cw[pa] = ~cw[pa];
            if (mode == 2) begin cw[pa] = ~cw[pa]; cw[pb] = ~cw[pb]; end
            if (mode == 3) cw = 12'($urandom);
            ref_decode(cw, md, ms, mec, meu);
            run_word(cw);
            check_out("rand", md, ms, mec, meu);
            if (mode <= 1) chk("rand_recover", 32'(bus_if.out_data), 32'(d));
            handshake();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
